// File: rtl/countdown_timer_ctrl_pkg.sv
// Shared definitions for the mm:ss countdown timer sequencer: state encoding and counter geometry.
package countdown_timer_ctrl_pkg;

    localparam int CNT_W   = 8;
    localparam int MAX_VAL = 59;    // must match the top value of the external counters

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SET_MIN = 3'd1,
        ST_SET_SEC = 3'd2,
        ST_RUN     = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    function automatic logic is_set_mode(input state_e s);
        return (s == ST_SET_MIN) || (s == ST_SET_SEC);
    endfunction

endpackage

// File: rtl/countdown_timer_ctrl_if.sv
// Button pulses, counter values and counter controls between the timer sequencer and its surroundings.
interface countdown_timer_ctrl_if;
    import countdown_timer_ctrl_pkg::*;

    logic             btn_start;
    logic             btn_mode;
    logic             btn_up;
    logic             btn_down;
    logic             btn_clear;
    logic [CNT_W-1:0] sec_count;
    logic [CNT_W-1:0] min_count;
    logic             sec_ce;
    logic             min_ce;
    logic             cnt_ld;
    logic             cnt_up_down;
    logic [CNT_W-1:0] cnt_load;
    logic             running;
    logic             set_min;
    logic             set_sec;
    logic             alarm;
    logic             blink;

    modport slave (
        input  btn_start, btn_mode, btn_up, btn_down, btn_clear, sec_count, min_count,
        output sec_ce, min_ce, cnt_ld, cnt_up_down, cnt_load, running, set_min, set_sec, alarm, blink
    );

    modport master (
        output btn_start, btn_mode, btn_up, btn_down, btn_clear, sec_count, min_count,
        input  sec_ce, min_ce, cnt_ld, cnt_up_down, cnt_load, running, set_min, set_sec, alarm, blink
    );

endinterface

// File: rtl/countdown_timer_ctrl_tick_gen.sv
// Timer tick generator: counts 0..DIV-1 while enabled and emits a one-cycle tick on the last count.
module countdown_timer_ctrl_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] TC = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         at_tc;

    assign at_tc  = (cnt_q == TC);
    assign tick_o = en_i && !clr_i && at_tc;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!en_i || clr_i || at_tc) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Set/run/alarm sequencer for an mm:ss countdown built from two mod-60 counters.
// Optional set-mode blink output is built only when TIMER_BLINK_EN is defined.
module countdown_timer_ctrl
    import countdown_timer_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
`ifdef TIMER_BLINK_EN
    , parameter int BLINK_DIV = 12_500_000
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    countdown_timer_ctrl_if.slave tif
);

    state_e state_q, state_d;
    logic   sec_ce_q, sec_ce_d, min_ce_q, min_ce_d;
    logic   ld_q, ld_d, ud_q, ud_d;
    logic   running_q, set_min_q, set_sec_q, alarm_q;
    logic   tick, busy, cnt_zero, up_only, down_only;

    // Counter values are stale in the cycle right after a strobe, so no decisions are taken then.
    assign busy      = sec_ce_q || min_ce_q;
    assign cnt_zero  = (tif.min_count == '0) && (tif.sec_count == '0);
    assign up_only   = tif.btn_up && !tif.btn_down;
    assign down_only = tif.btn_down && !tif.btn_up;

    countdown_timer_ctrl_tick_gen #(.DIV(TICK_DIV)) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (state_q == ST_RUN),
        .clr_i  (1'b0),
        .tick_o (tick)
    );

    always_comb begin
        state_d  = state_q;
        sec_ce_d = 1'b0;
        min_ce_d = 1'b0;
        ld_d     = 1'b0;
        ud_d     = 1'b0;
        if (!busy) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (tif.btn_clear) begin
                        {sec_ce_d, min_ce_d, ld_d} = 3'b111;
                    end else if (tif.btn_mode) begin
                        state_d = ST_SET_MIN;
                    end else if (tif.btn_start && !cnt_zero) begin
                        state_d = ST_RUN;
                    end
                end
                ST_SET_MIN, ST_SET_SEC: begin
                    if (tif.btn_clear) begin
                        {sec_ce_d, min_ce_d, ld_d} = 3'b111;
                    end else if (tif.btn_mode) begin
                        state_d = (state_q == ST_SET_MIN) ? ST_SET_SEC : ST_IDLE;
                    end else if (tif.btn_start) begin
                        state_d = cnt_zero ? ST_IDLE : ST_RUN;
                    end else if (up_only || down_only) begin
                        min_ce_d = (state_q == ST_SET_MIN);
                        sec_ce_d = (state_q == ST_SET_SEC);
                        ud_d     = up_only;
                    end
                end
                ST_RUN: begin
                    if (tif.btn_clear) begin
                        {sec_ce_d, min_ce_d, ld_d} = 3'b111;
                        state_d = ST_IDLE;
                    end else if (tif.btn_start) begin
                        state_d = ST_IDLE;
                    end else if (tick) begin
                        sec_ce_d = 1'b1;
                        min_ce_d = (tif.sec_count == '0);
                        if (tif.min_count == '0 && tif.sec_count == CNT_W'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (tif.btn_clear) begin
                        {sec_ce_d, min_ce_d, ld_d} = 3'b111;
                        state_d = ST_IDLE;
                    end else if (tif.btn_start || tif.btn_mode) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sec_ce_q  <= 1'b0;
            min_ce_q  <= 1'b0;
            ld_q      <= 1'b0;
            ud_q      <= 1'b0;
            running_q <= 1'b0;
            set_min_q <= 1'b0;
            set_sec_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sec_ce_q  <= sec_ce_d;
            min_ce_q  <= min_ce_d;
            ld_q      <= ld_d;
            ud_q      <= ud_d;
            running_q <= (state_d == ST_RUN);
            set_min_q <= (state_d == ST_SET_MIN);
            set_sec_q <= (state_d == ST_SET_SEC);
            alarm_q   <= (state_d == ST_DONE);
        end
    end

    assign tif.sec_ce      = sec_ce_q;
    assign tif.min_ce      = min_ce_q;
    assign tif.cnt_ld      = ld_q;
    assign tif.cnt_up_down = ud_q;
    assign tif.cnt_load    = '0;
    assign tif.running     = running_q;
    assign tif.set_min     = set_min_q;
    assign tif.set_sec     = set_sec_q;
    assign tif.alarm       = alarm_q;

`ifdef TIMER_BLINK_EN
    logic blink_tick, blink_q;

    countdown_timer_ctrl_tick_gen #(.DIV(BLINK_DIV)) u_blink_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (is_set_mode(state_q)),
        .clr_i  (1'b0),
        .tick_o (blink_tick)
    );

    // Entering a set mode from outside restarts the blink high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_q <= 1'b0;
        end else if (!is_set_mode(state_d)) begin
            blink_q <= 1'b0;
        end else if (!is_set_mode(state_q)) begin
            blink_q <= 1'b1;
        end else if (blink_tick) begin
            blink_q <= !blink_q;
        end
    end

    assign tif.blink = blink_q;
`else
    assign tif.blink = 1'b0;
`endif

endmodule
